// File: rtl/gpio_port.sv
// Memory-mapped GPIO: OUT/DIR/IN/TGL with an input synchroniser and registered reads.
// Defining GPIO_IRQ_EN adds the FLAG/IEN/POL/ANY registers, edge detection and irq.
module gpio_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN  = 3'd2, A_FLAG = 3'd3,
                           A_IEN = 3'd4, A_POL = 3'd5, A_ANY = 3'd6, A_TGL  = 3'd7;

    logic                             wr;
    logic [WIDTH-1:0]                 wdat;
    logic [WIDTH-1:0]                 out_q, out_d, dir_q, dir_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                 sync;
    logic [7:0]                       dout_q, dout_d;

    assign wr   = cs && we;
    assign wdat = din[WIDTH-1:0];
    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr) begin
            case (addr)
                A_OUT:   out_d = wdat;
                A_DIR:   dir_d = wdat;
                A_TGL:   out_d = out_q ^ wdat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            dir_q  <= '0;
            sync_q <= '0;
            dout_q <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            dout_q <= dout_d;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q, flag_q, flag_d, ien_q, ien_d, pol_q, pol_d, any_q, any_d;
    logic [WIDTH-1:0] rise, fall, hit, w1c;

    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;
    assign hit  = (any_q & (rise | fall)) | (~any_q & ((pol_q & rise) | (~pol_q & fall)));
    assign w1c  = (wr && addr == A_FLAG) ? wdat : '0;

    always_comb begin
        ien_d  = ien_q;
        pol_d  = pol_q;
        any_d  = any_q;
        // A new hit overrides a simultaneous W1C of the same bit.
        flag_d = (flag_q & ~w1c) | hit;
        if (wr) begin
            case (addr)
                A_IEN:   ien_d = wdat;
                A_POL:   pol_d = wdat;
                A_ANY:   any_d = wdat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            flag_q <= '0;
            ien_q  <= '0;
            pol_q  <= '0;
            any_q  <= '0;
        end else begin
            prev_q <= sync;
            flag_q <= flag_d;
            ien_q  <= ien_d;
            pol_q  <= pol_d;
            any_q  <= any_d;
        end
    end

    assign irq = |(flag_q & ien_q);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        dout_d = '0;
        case (addr)
            A_OUT:  dout_d[WIDTH-1:0] = out_q;
            A_DIR:  dout_d[WIDTH-1:0] = dir_q;
            A_IN:   dout_d[WIDTH-1:0] = sync;
`ifdef GPIO_IRQ_EN
            A_FLAG: dout_d[WIDTH-1:0] = flag_q;
            A_IEN:  dout_d[WIDTH-1:0] = ien_q;
            A_POL:  dout_d[WIDTH-1:0] = pol_q;
            A_ANY:  dout_d[WIDTH-1:0] = any_q;
`endif
            default: ;
        endcase
    end

    assign dout    = dout_q;
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
endmodule
